// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency/period meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic MODE_FREQ   = 1'b0;
  localparam logic MODE_PERIOD = 1'b1;

  localparam int unsigned SAT_W = 64;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max_v);
    return (v >= max_v) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Synchroniser chain for an asynchronous input plus a registered rising-edge pulse.
module sig_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // rise lags sig_in by SYNC_STAGES+1 cycles
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/freq_period_meter.sv
// Continuous frequency (edges per gate) or period (cycles per N periods) meter
// for an asynchronous input, with saturating counters and timeout.
module freq_period_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES    = 100_000_000,
  parameter int unsigned AVG_PERIODS    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             mode,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned PER_W  = (AVG_PERIODS > 1) ? $clog2(AVG_PERIODS) : 1;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(AVG_PERIODS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t             state;
  logic               cur_mode;
  logic [GATE_W-1:0]  gate_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [PER_W-1:0]   per_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [CNT_W-1:0]   cyc_cnt;
  logic               sticky_ovf;
  logic               rise;

  logic [CNT_W-1:0]   edge_inc;
  logic [CNT_W-1:0]   cyc_inc;
  logic               edge_at_max;
  logic               cyc_at_max;

  sig_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .sig_in  (sig_in),
    .rise    (rise)
  );

  assign edge_inc    = CNT_W'(sat_inc(SAT_W'(edge_cnt), SAT_W'(CNT_MAX)));
  assign cyc_inc     = CNT_W'(sat_inc(SAT_W'(cyc_cnt), SAT_W'(CNT_MAX)));
  assign edge_at_max = (edge_cnt == CNT_MAX);
  assign cyc_at_max  = (cyc_cnt == CNT_MAX);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cur_mode     <= MODE_FREQ;
      gate_cnt     <= '0;
      to_cnt       <= '0;
      per_cnt      <= '0;
      edge_cnt     <= '0;
      cyc_cnt      <= '0;
      sticky_ovf   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        // DONE lasts one cycle and restarts exactly like IDLE does
        IDLE, DONE: begin
          gate_cnt   <= '0;
          to_cnt     <= '0;
          per_cnt    <= '0;
          edge_cnt   <= '0;
          cyc_cnt    <= '0;
          sticky_ovf <= 1'b0;
          cur_mode   <= mode;
          if (enable) begin
            state <= (mode == MODE_PERIOD) ? WAIT_EDGE : MEASURE;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        WAIT_EDGE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rise) begin
            state   <= MEASURE;
            cyc_cnt <= '0;
            per_cnt <= '0;
            to_cnt  <= '0;
          end else if (to_cnt == TO_LAST) begin
            state        <= DONE;
            result       <= '0;
            result_valid <= 1'b1;
            overflow     <= sticky_ovf;
            timeout      <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        MEASURE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cur_mode == MODE_FREQ) begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            if (rise) begin
              edge_cnt <= edge_inc;
              if (edge_at_max) sticky_ovf <= 1'b1;
            end
            // an edge in the last gate cycle still counts
            if (gate_cnt == GATE_LAST) begin
              state        <= DONE;
              result       <= rise ? edge_inc : edge_cnt;
              result_valid <= 1'b1;
              overflow     <= sticky_ovf | (rise & edge_at_max);
              timeout      <= 1'b0;
            end
          end else begin
            cyc_cnt <= cyc_inc;
            if (cyc_at_max) sticky_ovf <= 1'b1;
            if (rise) begin
              if (per_cnt == PER_LAST) begin
                state        <= DONE;
                result       <= cyc_inc;
                result_valid <= 1'b1;
                overflow     <= sticky_ovf | cyc_at_max;
                timeout      <= 1'b0;
              end else begin
                per_cnt <= per_cnt + PER_W'(1);
                to_cnt  <= '0;
              end
            end else if (to_cnt == TO_LAST) begin
              state        <= DONE;
              result       <= '0;
              result_valid <= 1'b1;
              overflow     <= sticky_ovf | cyc_at_max;
              timeout      <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_period_meter.sv
// Directed bench for freq_period_meter: two instances share clock, reset and sig_in.
module tb_freq_period_meter;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic        en_a, mode_a, en_b, mode_b;
  logic [31:0] res_a;
  logic [7:0]  res_b;
  logic        rv_a, ov_a, to_a, busy_a;
  logic        rv_b, ov_b, to_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;
  int gen_period = 0;

  always #5 sys_clk = ~sys_clk;

  freq_period_meter #(
    .GATE_CYCLES(1000), .AVG_PERIODS(4), .TIMEOUT_CYCLES(500), .CNT_W(32), .SYNC_STAGES(2)
  ) dut_a (
    .sys_clk(sys_clk), .rst(rst), .sig_in(sig_in), .enable(en_a), .mode(mode_a),
    .result(res_a), .result_valid(rv_a), .overflow(ov_a), .timeout(to_a), .busy(busy_a)
  );

  freq_period_meter #(
    .GATE_CYCLES(1000), .AVG_PERIODS(1), .TIMEOUT_CYCLES(500), .CNT_W(8), .SYNC_STAGES(2)
  ) dut_b (
    .sys_clk(sys_clk), .rst(rst), .sig_in(sig_in), .enable(en_b), .mode(mode_b),
    .result(res_b), .result_valid(rv_b), .overflow(ov_b), .timeout(to_b), .busy(busy_b)
  );

  // Square-wave source; gen_period==0 holds the line low.
  initial begin
    int ph;
    ph = 0;
    sig_in = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (gen_period == 0) begin
        sig_in = 1'b0;
        ph = 0;
      end else begin
        sig_in = (ph < gen_period / 2);
        ph = (ph >= gen_period - 1) ? 0 : ph + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge sys_clk);
    #1;
  endtask

  // Returns cycles until result_valid is seen, or 0 if the budget expires.
  task automatic wait_valid(input bit sel_b, input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge sys_clk);
      #1;
      if ((sel_b ? rv_b : rv_a) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    en_a = 1'b0; mode_a = 1'b0;
    en_b = 1'b0; mode_b = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_res_a",  res_a, 32'd0);
    chk("rst_rv_a",   32'(rv_a), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_ov_b",   32'(ov_b), 32'd0);
    chk("rst_to_b",   32'(to_b), 32'd0);
    rst = 1'b0;

    // Frequency mode, period 10, gate 1000
    gen_period = 10;
    cyc(30);
    en_a = 1'b1;
    wait_valid(1'b0, 2000, n);
    chk("freq1_lat", 32'(n), 32'd1001);
    chk("freq1_res", res_a, 32'd100);
    chk("freq1_ov",  32'(ov_a), 32'd0);
    chk("freq1_to",  32'(to_a), 32'd0);
    chk("freq1_busy", 32'(busy_a), 32'd1);
    wait_valid(1'b0, 2000, n);
    chk("freq2_lat", 32'(n), 32'd1001);
    chk("freq2_res", res_a, 32'd100);
    cyc(1);
    chk("freq_pulse_w", 32'(rv_a), 32'd0);
    en_a = 1'b0;
    cyc(1);
    chk("freq_stop_busy", 32'(busy_a), 32'd0);

    // Period mode, 4 x 37 cycles, with a mode flip mid-measurement
    gen_period = 37;
    cyc(50);
    mode_a = 1'b1;
    en_a = 1'b1;
    wait_valid(1'b0, 2000, n);
    chk("per1_seen", 32'(n > 0), 32'd1);
    chk("per1_res",  res_a, 32'd148);
    chk("per1_to",   32'(to_a), 32'd0);
    cyc(50);
    mode_a = 1'b0;
    wait_valid(1'b0, 2000, n);
    chk("per2_seen", 32'(n > 0), 32'd1);
    chk("per2_res",  res_a, 32'd148);
    chk("per2_to",   32'(to_a), 32'd0);

    // Abort a frequency window half way
    cyc(500);
    en_a = 1'b0;
    cyc(1);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_res",  res_a, 32'd148);
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge sys_clk);
      #1;
      if (rv_a === 1'b1) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    chk("abort_res_kept", res_a, 32'd148);

    // Period timeout with input held low, then recovery at 20 cycles
    gen_period = 0;
    cyc(10);
    mode_b = 1'b1;
    en_b = 1'b1;
    wait_valid(1'b1, 2000, n);
    chk("tmo_lat", 32'(n), 32'd501);
    chk("tmo_res", 32'(res_b), 32'd0);
    chk("tmo_to",  32'(to_b), 32'd1);
    gen_period = 20;
    wait_valid(1'b1, 2000, n);
    chk("rec_seen", 32'(n > 0), 32'd1);
    chk("rec_res",  32'(res_b), 32'd20);
    chk("rec_to",   32'(to_b), 32'd0);
    en_b = 1'b0;
    cyc(2);

    // 8-bit overflow at period 2, then clean at period 10
    mode_b = 1'b0;
    gen_period = 2;
    cyc(10);
    en_b = 1'b1;
    wait_valid(1'b1, 2000, n);
    chk("ovf_res", 32'(res_b), 32'd255);
    chk("ovf_ov",  32'(ov_b), 32'd1);
    chk("ovf_to",  32'(to_b), 32'd0);
    en_b = 1'b0;
    gen_period = 10;
    cyc(20);
    en_b = 1'b1;
    wait_valid(1'b1, 2000, n);
    chk("noovf_lat", 32'(n), 32'd1001);
    chk("noovf_res", 32'(res_b), 32'd100);
    chk("noovf_ov",  32'(ov_b), 32'd0);
    en_b = 1'b0;
    cyc(2);

    // Asynchronous reset mid-window
    mode_a = 1'b0;
    en_a = 1'b1;
    cyc(300);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_res_a",  res_a, 32'd0);
    chk("arst_busy_a", 32'(busy_a), 32'd0);
    chk("arst_res_b",  32'(res_b), 32'd0);
    chk("arst_ov_b",   32'(ov_b), 32'd0);
    en_a = 1'b0;
    #2;
    rst = 1'b0;
    cyc(20);
    en_a = 1'b1;
    wait_valid(1'b0, 2000, n);
    chk("post_rst_lat", 32'(n), 32'd1001);
    chk("post_rst_res", res_a, 32'd100);
    chk("post_rst_ov",  32'(ov_a), 32'd0);
    chk("post_rst_to",  32'(to_a), 32'd0);
    en_a = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_period_meter.md
Name: freq_period_meter

Overview:
Parametrised successor to the single-mode gated frequency counter. It measures an asynchronous input `sig_in` in one of two modes:
- Frequency mode: counts rising edges over a programmable gate window.
- Period mode: counts `sys_clk` cycles across N input periods, with a no-signal timeout.

It runs continuously while enabled and delivers each result with a one-cycle valid strobe and status flags. It feeds the oscilloscope display and trigger logic.

Parameters:
- GATE_CYCLES, 100_000_000: gate length in `sys_clk` cycles for frequency mode (>=2).
- AVG_PERIODS, 1: number of input periods accumulated in period mode (>=1).
- TIMEOUT_CYCLES, 200_000_000: cycles without a qualifying edge before period mode aborts (>=2).
- CNT_W, 32: width of the result and internal counters.
- SYNC_STAGES, 2: synchroniser depth on `sig_in` (>=2).

Ports:
- sys_clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- sig_in, in, 1: measured signal, asynchronous to `sys_clk`.
- enable, in, 1: run measurements while high.
- mode, in, 1: 0 = frequency, 1 = period. Sampled only when leaving IDLE or DONE.
- result, out, CNT_W: last completed measurement (edge count or cycle count).
- result_valid, out, 1: one-cycle pulse when `result` and the flags update.
- overflow, out, 1: counter saturated during the last measurement.
- timeout, out, 1: last period measurement timed out.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - FSM in IDLE, all counters 0, synchroniser flops 0.
- Input path:
  - `sig_in` passes through SYNC_STAGES flops, then one edge-detect flop.
  - The rise pulse `rise` is one cycle wide and lags `sig_in` by SYNC_STAGES+1 cycles.
  - Only rising edges are counted.
- FSM states: IDLE, WAIT_EDGE, MEASURE, DONE.
- IDLE:
  - enable=1 and mode=0 -> MEASURE.
  - enable=1 and mode=1 -> WAIT_EDGE.
  - Entering either state clears gate_cnt, edge_cnt, cyc_cnt, per_cnt, to_cnt and the sticky overflow.
- Frequency mode, MEASURE:
  - gate_cnt increments every cycle.
  - edge_cnt increments on `rise`, saturating at 2^CNT_W-1; an increment attempted at the saturated value sets sticky overflow.
  - At gate_cnt==GATE_CYCLES-1 -> DONE. A `rise` in that cycle is counted.
  - result <= edge_cnt including that final edge.
- Period mode, WAIT_EDGE:
  - to_cnt increments every cycle.
  - On `rise` -> MEASURE, with cyc_cnt=0, per_cnt=0, to_cnt=0.
  - At to_cnt==TIMEOUT_CYCLES-1 -> DONE with timeout=1 and result=0.
- Period mode, MEASURE:
  - cyc_cnt increments every cycle, saturating at 2^CNT_W-1 with sticky overflow.
  - On `rise`:
    - If per_cnt==AVG_PERIODS-1: result <= cyc_cnt+1 (saturated) and go to DONE.
    - Otherwise: per_cnt++ and to_cnt=0.
  - Without an edge, to_cnt increments; at TIMEOUT_CYCLES-1 -> DONE with timeout=1 and result=0.
  - A steady input of P cycles per period gives result = P*AVG_PERIODS.
- DONE (one cycle):
  - result_valid=1; `overflow` and `timeout` outputs are updated.
  - The flags hold until the next result_valid.
  - Next state: enable=1 re-samples `mode` -> MEASURE or WAIT_EDGE (clears as on leaving IDLE); enable=0 -> IDLE.
  - Frequency mode therefore has exactly one dead cycle per window; an edge in DONE is not counted.
- enable falls in WAIT_EDGE or MEASURE:
  - Abort to IDLE on the next edge.
  - No result_valid; result and flags keep their previous values.
- `mode` change during a measurement is ignored until DONE or IDLE.
- Reset asserted mid-measurement: immediate return to reset state; the partial measurement is discarded.
- Widths:
  - Counters are CNT_W bits.
  - gate_cnt and to_cnt are sized with $clog2 of their parameter.
  - No wrap-around anywhere: saturate only.

Decomposition:
- Package `freq_meter_pkg`:
  - FSM state enum (IDLE, WAIT_EDGE, MEASURE, DONE).
  - MODE_FREQ=1'b0, MODE_PERIOD=1'b1.
  - Saturating-increment function.
- Sub-module `sig_edge_sync` (params SYNC_STAGES): synchroniser chain plus rising-edge pulse; outputs `rise`.
- The FSM and counters stay in the top level.

Test Plan:
1. Frequency, square wave: GATE_CYCLES=1000, mode=0, `sig_in` period 10 cycles -> result_valid every 1001 cycles, result=100 (±1 on the first window), overflow=0, timeout=0.
2. Period averaging: mode=1, AVG_PERIODS=4, period 37 cycles -> result=148 on every valid, timeout=0. Changing `mode` mid-measurement has no effect until DONE.
3. Timeout: mode=1, TIMEOUT_CYCLES=500, `sig_in` held low -> result_valid 501 cycles after enable, result=0, timeout=1. Then restore a 20-cycle period -> next result=20 (AVG_PERIODS=1), timeout=0.
4. Overflow: CNT_W=8, GATE_CYCLES=1000, mode=0, period 2 cycles -> result=255, overflow=1. Period 10 cycles -> next result=100, overflow=0.
5. Abort: drop enable at gate_cnt=500 -> no result_valid, busy=0 next cycle, previous result retained.
6. Reset mid-measurement: assert rst asynchronously (between clock edges) at cycle 300 of the gate -> all outputs 0 immediately. After release, the first result is a full clean window.
